mc_ctrl_fsm: RTL and testbench



---
 rtl/mc_ctrl_fsm_if.sv | 34 +++
 rtl/mc_ctrl_fsm.sv | 183 ++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle sequencer (master) and the IR/datapath side (slave).
interface mc_ctrl_fsm_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       mem_ready;
    logic [2:0] status;
    logic       pc_we;
    logic       ir_we;
    logic [1:0] npc_sel;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic       dm_re;
    logic       dm_we;
    logic       flag_we;
    logic       err;

    modport master (
        input  opcode, funct, zero, overflow, mem_ready,
        output status, pc_we, ir_we, npc_sel, reg_we, reg_dst, wd_sel,
               alu_src, alu_op, ext_op, dm_re, dm_we, flag_we, err
    );

    modport slave (
        output opcode, funct, zero, overflow, mem_ready,
        input  status, pc_we, ir_we, npc_sel, reg_we, reg_dst, wd_sel,
               alu_src, alu_op, ext_op, dm_re, dm_we, flag_we, err
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with DM handshake and wait timeout.
// Optional macro ADDI_OVF_FLAG_EN: addi writes the overflow flag and suppresses its GPR write on overflow.
module mc_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 8
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);

    typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4, S5 = 3'd5} state_t;
    typedef enum logic [3:0] {
        I_ILL, I_NOP, I_ADDU, I_SUBU, I_SLT, I_JR, I_ORI, I_LUI,
        I_ADDI, I_ADDIU, I_LW, I_SW, I_BEQ, I_J, I_JAL
    } instr_t;

    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_SLT = 3'd3, ALU_PASSB = 3'd4;
    localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
    localparam logic [1:0] NPC_SEQ = 2'd0, NPC_BR = 2'd1, NPC_J = 2'd2, NPC_JR = 2'd3;
    localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
    localparam logic [1:0] WD_ALU = 2'd0, WD_DM = 2'd1, WD_PC = 2'd2;

    state_t          state_reg, state_next;
    logic [TO_W-1:0] wait_cnt_reg, wait_cnt_next;
    instr_t          instr;
    logic            timeout;

    logic [2:0] alu_op_d;
    logic       alu_src_d;
    logic [1:0] ext_op_d, reg_dst_d, wd_sel_d;

    logic       pc_we, ir_we, reg_we, alu_src, dm_re, dm_we, flag_we, err;
    logic [1:0] npc_sel, reg_dst, wd_sel, ext_op;
    logic [2:0] alu_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S0;
            wait_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    // IR is stable from S2 onward, so decode straight off opcode/funct.
    always_comb begin
        instr = I_ILL;
        case (bus.opcode)
            6'h00: begin
                case (bus.funct)
                    6'h00:   instr = I_NOP;
                    6'h08:   instr = I_JR;
                    6'h21:   instr = I_ADDU;
                    6'h23:   instr = I_SUBU;
                    6'h2A:   instr = I_SLT;
                    default: instr = I_ILL;
                endcase
            end
            6'h02:   instr = I_J;
            6'h03:   instr = I_JAL;
            6'h04:   instr = I_BEQ;
            6'h08:   instr = I_ADDI;
            6'h09:   instr = I_ADDIU;
            6'h0D:   instr = I_ORI;
            6'h0F:   instr = I_LUI;
            6'h23:   instr = I_LW;
            6'h2B:   instr = I_SW;
            default: instr = I_ILL;
        endcase
    end

    always_comb begin
        alu_op_d  = ALU_ADD;
        alu_src_d = 1'b0;
        ext_op_d  = EXT_ZERO;
        reg_dst_d = DST_RT;
        wd_sel_d  = WD_ALU;
        case (instr)
            I_ADDU:  reg_dst_d = DST_RD;
            I_SUBU:  begin alu_op_d = ALU_SUB; reg_dst_d = DST_RD; end
            I_SLT:   begin alu_op_d = ALU_SLT; reg_dst_d = DST_RD; end
            I_ORI:   begin alu_op_d = ALU_OR;  alu_src_d = 1'b1; end
            I_LUI:   begin alu_op_d = ALU_PASSB; alu_src_d = 1'b1; ext_op_d = EXT_LUI; end
            I_ADDI, I_ADDIU, I_SW: begin alu_src_d = 1'b1; ext_op_d = EXT_SIGN; end
            I_LW:    begin alu_src_d = 1'b1; ext_op_d = EXT_SIGN; wd_sel_d = WD_DM; end
            I_BEQ:   alu_op_d = ALU_SUB;
            default: ;
        endcase
    end

    assign timeout = (wait_cnt_reg == TO_W'(MEM_TIMEOUT));

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = '0;
        pc_we   = 1'b0;  ir_we   = 1'b0;  npc_sel = NPC_SEQ;
        reg_we  = 1'b0;  reg_dst = DST_RT; wd_sel  = WD_ALU;
        alu_src = 1'b0;  alu_op  = ALU_ADD; ext_op = EXT_ZERO;
        dm_re   = 1'b0;  dm_we   = 1'b0;  flag_we = 1'b0;  err = 1'b0;
        case (state_reg)
            S0: state_next = S1;
            S1: begin
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                state_next = S2;
            end
            S2: begin
                state_next = S1;
                case (instr)
                    I_J:   begin pc_we = 1'b1; npc_sel = NPC_J; end
                    I_JAL: begin
                        pc_we   = 1'b1; npc_sel = NPC_J;
                        reg_we  = 1'b1; reg_dst = DST_RA; wd_sel = WD_PC;
                    end
                    I_JR:  begin pc_we = 1'b1; npc_sel = NPC_JR; end
                    I_NOP: ;
                    I_ILL: err = 1'b1;
                    default: state_next = S3;
                endcase
            end
            S3: begin
                alu_op = alu_op_d; alu_src = alu_src_d; ext_op = ext_op_d;
                if (instr == I_BEQ) begin
                    pc_we      = bus.zero;
                    npc_sel    = NPC_BR;
                    state_next = S1;
                end else if (instr == I_LW || instr == I_SW) begin
                    state_next = S4;
                end else begin
                    state_next = S5;
                end
            end
            S4: begin
                alu_op = alu_op_d; alu_src = alu_src_d; ext_op = ext_op_d;
                // Abort wins over a late mem_ready once the wait budget is spent.
                if (timeout) begin
                    err        = 1'b1;
                    state_next = S1;
                end else begin
                    dm_re = (instr == I_LW);
                    dm_we = (instr == I_SW);
                    if (bus.mem_ready) begin
                        state_next = (instr == I_LW) ? S5 : S1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + TO_W'(1);
                    end
                end
            end
            S5: begin
                alu_op = alu_op_d; alu_src = alu_src_d; ext_op = ext_op_d;
                reg_we  = 1'b1;
                reg_dst = reg_dst_d;
                wd_sel  = wd_sel_d;
`ifdef ADDI_OVF_FLAG_EN
                if (instr == I_ADDI) begin
                    flag_we = 1'b1;
                    reg_we  = ~bus.overflow;
                end
`endif
                state_next = S1;
            end
            default: state_next = S0;
        endcase
    end

    assign bus.status  = state_reg;
    assign bus.pc_we   = pc_we;
    assign bus.ir_we   = ir_we;
    assign bus.npc_sel = npc_sel;
    assign bus.reg_we  = reg_we;
    assign bus.reg_dst = reg_dst;
    assign bus.wd_sel  = wd_sel;
    assign bus.alu_src = alu_src;
    assign bus.alu_op  = alu_op;
    assign bus.ext_op  = ext_op;
    assign bus.dm_re   = dm_re;
    assign bus.dm_we   = dm_we;
    assign bus.flag_we = flag_we;
    assign bus.err     = err;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: decode table vectors, corner-case sequences, and random instructions vs a cycle-count model.
module tb_mc_ctrl_fsm;

`ifdef ADDI_OVF_FLAG_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif
    localparam int TMO   = 15;
    localparam int STUCK = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mc_ctrl_fsm_if bus();

    mc_ctrl_fsm #(.MEM_TIMEOUT(TMO), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Per-instruction observations gathered by run_instr.
    int         lat, n_pcw, n_rwe, n_dre, n_dwe, n_err, n_flg;
    int         got_s3, rwe_state;
    logic [2:0] cap_aop;
    logic       cap_asrc;
    logic [1:0] cap_ext, cap_rdst, cap_wds;
    logic [8:0] s2_vec;
    logic       s3_pcw;
    logic [1:0] s3_npc;
    logic [2:0] trace[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Runs one instruction starting with the DUT sampled in S1; returns when it is back in S1.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input logic ov, input int waits);
        int s4 = 0;
        bit done = 0;
        lat = 0; n_pcw = 0; n_rwe = 0; n_dre = 0; n_dwe = 0; n_err = 0; n_flg = 0;
        got_s3 = 0; rwe_state = 0; cap_aop = 0; cap_asrc = 0; cap_ext = 0;
        cap_rdst = 0; cap_wds = 0; s2_vec = 0; s3_pcw = 0; s3_npc = 0;
        trace.delete();
        bus.opcode = op; bus.funct = fn; bus.zero = z; bus.overflow = ov;
        for (int k = 0; k < 100 && !done; k++) begin
            if (bus.status == 3'd4) begin
                bus.mem_ready = (s4 >= waits);
                s4++;
            end else begin
                bus.mem_ready = 1'b0;
            end
            #1;
            trace.push_back(bus.status);
            n_pcw += bus.pc_we; n_dre += bus.dm_re; n_dwe += bus.dm_we;
            n_err += bus.err;   n_flg += bus.flag_we;
            if (bus.reg_we) begin
                n_rwe++; cap_rdst = bus.reg_dst; cap_wds = bus.wd_sel; rwe_state = bus.status;
            end
            if (bus.status == 3'd2)
                s2_vec = {bus.pc_we, bus.npc_sel, bus.reg_we, bus.reg_dst, bus.wd_sel, bus.err};
            if (bus.status == 3'd3) begin
                got_s3 = 1; cap_aop = bus.alu_op; cap_asrc = bus.alu_src; cap_ext = bus.ext_op;
                s3_pcw = bus.pc_we; s3_npc = bus.npc_sel;
            end
            lat++;
            @(negedge clk);
            if (bus.status == 3'd1) done = 1;
        end
        if (!done) chk("instr_timeout", 0, 1);
        $display("instr op=%02h fn=%02h z=%0d ov=%0d waits=%0d lat=%0d pcw=%0d rwe=%0d err=%0d",
                 op, fn, z, ov, waits, lat, n_pcw, n_rwe, n_err);
    endtask

    typedef struct {
        int lat; int pcw; int rwe; int dre; int dwe; int err; int flg;
    } exp_t;

    // Expected event counts for one instruction, from the instruction set rules.
    function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                   input logic ov, input int waits);
        exp_t e;
        bit rtype_alu = (op == 6'h00) && (fn == 6'h21 || fn == 6'h23 || fn == 6'h2A);
        bit itype_alu = (op == 6'h0D || op == 6'h0F || op == 6'h08 || op == 6'h09);
        bit is_jr     = (op == 6'h00) && (fn == 6'h08);
        bit jumpish   = (op == 6'h02) || (op == 6'h03) || is_jr;
        bit is_lw     = (op == 6'h23);
        bit is_sw     = (op == 6'h2B);
        bit is_beq    = (op == 6'h04);
        bit is_nop    = (op == 6'h00) && (fn == 6'h00);
        bit legal     = rtype_alu || itype_alu || jumpish || is_lw || is_sw || is_beq || is_nop;
        bit to        = (waits >= TMO);
        bit addi_ovf  = FEAT && (op == 6'h08) && ov;
        e = '{default: 0};
        if (is_lw || is_sw) e.lat = to ? 4 + TMO : (is_lw ? 5 : 4) + waits;
        else if (is_beq) e.lat = 3;
        else if (rtype_alu || itype_alu) e.lat = 4;
        else e.lat = 2;
        e.pcw = 1 + (jumpish ? 1 : 0) + ((is_beq && z) ? 1 : 0);
        e.rwe = ((rtype_alu || itype_alu) && !addi_ovf) || op == 6'h03 || (is_lw && !to);
        e.dre = is_lw ? (to ? TMO : waits + 1) : 0;
        e.dwe = is_sw ? (to ? TMO : waits + 1) : 0;
        e.err = !legal || ((is_lw || is_sw) && to);
        e.flg = FEAT && (op == 6'h08);
        return e;
    endfunction

    typedef struct {
        logic [5:0] op; logic [5:0] fn; int lat; int pcw; int rwe; int err; int has_s3;
        logic [2:0] aop; logic asrc; logic [1:0] ext; logic [1:0] rdst; logic [1:0] wds;
    } vec_t;

    vec_t tbl[$];
    logic [5:0] pool_op[$];
    logic [5:0] pool_fn[$];

    initial begin
        exp_t e;
        int tr;
        bit seen;
        //            op     fn    lat pcw rwe err s3  aop   asrc  ext   rdst  wds
        tbl.push_back('{6'h00, 6'h21, 4, 1, 1, 0, 1, 3'd0, 1'b0, 2'd0, 2'd1, 2'd0});
        tbl.push_back('{6'h00, 6'h23, 4, 1, 1, 0, 1, 3'd1, 1'b0, 2'd0, 2'd1, 2'd0});
        tbl.push_back('{6'h00, 6'h2A, 4, 1, 1, 0, 1, 3'd3, 1'b0, 2'd0, 2'd1, 2'd0});
        tbl.push_back('{6'h0D, 6'h00, 4, 1, 1, 0, 1, 3'd2, 1'b1, 2'd0, 2'd0, 2'd0});
        tbl.push_back('{6'h0F, 6'h00, 4, 1, 1, 0, 1, 3'd4, 1'b1, 2'd2, 2'd0, 2'd0});
        tbl.push_back('{6'h08, 6'h00, 4, 1, 1, 0, 1, 3'd0, 1'b1, 2'd1, 2'd0, 2'd0});
        tbl.push_back('{6'h09, 6'h00, 4, 1, 1, 0, 1, 3'd0, 1'b1, 2'd1, 2'd0, 2'd0});
        tbl.push_back('{6'h23, 6'h00, 5, 1, 1, 0, 1, 3'd0, 1'b1, 2'd1, 2'd0, 2'd1});
        tbl.push_back('{6'h2B, 6'h00, 4, 1, 0, 0, 1, 3'd0, 1'b1, 2'd1, 2'd0, 2'd0});
        tbl.push_back('{6'h04, 6'h00, 3, 1, 0, 0, 1, 3'd1, 1'b0, 2'd0, 2'd0, 2'd0});
        tbl.push_back('{6'h02, 6'h00, 2, 2, 0, 0, 0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0});
        tbl.push_back('{6'h03, 6'h00, 2, 2, 1, 0, 0, 3'd0, 1'b0, 2'd0, 2'd2, 2'd2});
        tbl.push_back('{6'h00, 6'h08, 2, 2, 0, 0, 0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0});
        tbl.push_back('{6'h00, 6'h00, 2, 1, 0, 0, 0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0});
        tbl.push_back('{6'h3F, 6'h00, 2, 1, 0, 1, 0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0});
        tbl.push_back('{6'h00, 6'h3F, 2, 1, 0, 1, 0, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0});
        foreach (tbl[i]) begin pool_op.push_back(tbl[i].op); pool_fn.push_back(tbl[i].fn); end

        bus.opcode = 0; bus.funct = 0; bus.zero = 0; bus.overflow = 0; bus.mem_ready = 0;

        // Reset state, then release into fetch.
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({bus.status, bus.pc_we, bus.ir_we, bus.npc_sel, bus.reg_we,
            bus.reg_dst, bus.wd_sel, bus.alu_src, bus.alu_op, bus.ext_op, bus.dm_re, bus.dm_we,
            bus.flag_we, bus.err}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("fetch_status", int'(bus.status), 1);
        chk("fetch_ir_pc_we", int'({bus.ir_we, bus.pc_we, bus.npc_sel}), 4'b1100);

        // addu: status walk 1,2,3,5 and a single S5 write to rd.
        run_instr(6'h00, 6'h21, 1'b0, 1'b0, 0);
        tr = 0;
        foreach (trace[i]) tr = tr * 8 + int'(trace[i]);
        chk("addu_trace", tr, 12'o1235);
        chk("addu_rwe_cnt", n_rwe, 1);
        chk("addu_rwe_state", rwe_state, 5);

        // Decode table.
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].fn, 1'b0, 1'b0, 0);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_pcw", i), n_pcw, tbl[i].pcw);
            chk($sformatf("tbl%0d_rwe", i), n_rwe, tbl[i].rwe);
            chk($sformatf("tbl%0d_err", i), n_err, tbl[i].err);
            chk($sformatf("tbl%0d_s3", i), got_s3, tbl[i].has_s3);
            if (tbl[i].has_s3 != 0)
                chk($sformatf("tbl%0d_alu", i), int'({cap_aop, cap_asrc, cap_ext}),
                    int'({tbl[i].aop, tbl[i].asrc, tbl[i].ext}));
            if (tbl[i].rwe != 0)
                chk($sformatf("tbl%0d_wb", i), int'({cap_rdst, cap_wds}), int'({tbl[i].rdst, tbl[i].wds}));
        end

        // lw with three wait cycles.
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 3);
        chk("lw3_lat", lat, 8);
        chk("lw3_dm_re", n_dre, 4);
        chk("lw3_wd_sel", int'(cap_wds), 1);
        chk("lw3_err", n_err, 0);

        // sw with mem_ready stuck low: abort after the wait budget.
        run_instr(6'h2B, 6'h00, 1'b0, 1'b0, STUCK);
        chk("sw_to_err", n_err, 1);
        chk("sw_to_dm_we", n_dwe, TMO);
        chk("sw_to_rwe", n_rwe, 0);
        chk("sw_to_lat", lat, 4 + TMO);

        // beq taken and not taken.
        run_instr(6'h04, 6'h00, 1'b1, 1'b0, 0);
        chk("beq_t_s3", int'({s3_pcw, s3_npc}), 3'b101);
        chk("beq_t_lat", lat, 3);
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, 0);
        chk("beq_nt_pcw", int'(s3_pcw), 0);
        chk("beq_nt_lat", lat, 3);

        // jal and an illegal opcode, observed in decode.
        run_instr(6'h03, 6'h00, 1'b0, 1'b0, 0);
        chk("jal_s2", int'(s2_vec), int'({1'b1, 2'd2, 1'b1, 2'd2, 2'd2, 1'b0}));
        run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 0);
        chk("ill_s2", int'(s2_vec), int'({1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b1}));
        chk("ill_writes", n_pcw + n_rwe, 1);

        // addi with overflow.
        run_instr(6'h08, 6'h00, 1'b0, 1'b1, 0);
        chk("addi_ovf_rwe", n_rwe, FEAT ? 0 : 1);
        chk("addi_ovf_flag", n_flg, FEAT ? 1 : 0);

        // Reset while waiting in MEM.
        bus.opcode = 6'h2B; bus.funct = 6'h00; bus.mem_ready = 1'b0;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (bus.status == 3'd4) seen = 1;
        end
        chk("rst_s4_reached", int'(seen), 1);
        chk("rst_s4_dm_we", int'(bus.dm_we), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_s4_state", int'({bus.status, bus.dm_re, bus.dm_we}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_s4_refetch", int'(bus.status), 1);

        // Random instructions against the model.
        for (int r = 0; r < 60; r++) begin
            logic [5:0] op, fn;
            logic z, ov;
            int w, idx;
            if ($urandom_range(0, 3) == 0) begin
                op = 6'($urandom); fn = 6'($urandom);
            end else begin
                idx = $urandom_range(0, pool_op.size() - 1);
                op = pool_op[idx]; fn = pool_fn[idx];
            end
            z  = 1'($urandom);
            ov = 1'($urandom);
            w  = ($urandom_range(0, 5) == 0) ? STUCK : $urandom_range(0, TMO - 1);
            e  = model(op, fn, z, ov, w);
            run_instr(op, fn, z, ov, w);
            chk($sformatf("rnd%0d_lat", r), lat, e.lat);
            chk($sformatf("rnd%0d_pcw", r), n_pcw, e.pcw);
            chk($sformatf("rnd%0d_rwe", r), n_rwe, e.rwe);
            chk($sformatf("rnd%0d_dre", r), n_dre, e.dre);
            chk($sformatf("rnd%0d_dwe", r), n_dwe, e.dwe);
            chk($sformatf("rnd%0d_err", r), n_err, e.err);
            chk($sformatf("rnd%0d_flg", r), n_flg, e.flg);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
